// File: rtl/hit_event_scheduler_pkg.sv
// Shared types for the hit event scheduler slice.
// Package hit_pkg: hit event enum, per-ball hit set, encoded event, FSM
// state type and the hole priority encoder.
package hit_pkg;

    localparam int unsigned NUM_HOLES  = 6;
    localparam int unsigned HOLE_NUM_W = 3;
    localparam int unsigned STAT_W     = 16;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_BORDER = 2'd1,
        EV_BALL   = 2'd2,
        EV_HOLE   = 2'd3
    } hit_ev_t;

    typedef struct packed {
        logic                 border;
        logic                 ball;
        logic [NUM_HOLES-1:0] hole;
    } ball_hits_t;

    typedef struct packed {
        hit_ev_t               ev;
        logic [HOLE_NUM_W-1:0] hole_num;
    } hit_enc_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_W = 2'd1,
        ISSUE_R = 2'd2
    } sched_state_t;

    // HOLE > BALL > BORDER > NONE; the downward scan lets the lowest hole index win.
    function automatic hit_enc_t encode_hits(input ball_hits_t h);
        hit_enc_t e;
        e.ev       = EV_NONE;
        e.hole_num = '0;
        if (h.border) e.ev = EV_BORDER;
        if (h.ball)   e.ev = EV_BALL;
        for (int i = int'(NUM_HOLES) - 1; i >= 0; i--) begin
            if (h.hole[i]) begin
                e.ev       = EV_HOLE;
                e.hole_num = HOLE_NUM_W'(i + 1);
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/hit_event_scheduler_if.sv
// Event handshake bundle between the scheduler and the ball motion logic.
// master: drives evValid/evBall/evType/evHoleNum, samples evReady.
// slave : the consumer side.
interface hit_event_scheduler_if;
    import hit_pkg::*;

    logic                  evValid;
    logic                  evReady;
    logic                  evBall;
    hit_ev_t               evType;
    logic [HOLE_NUM_W-1:0] evHoleNum;

    modport master (output evValid, evBall, evType, evHoleNum, input evReady);
    modport slave  (input evValid, evBall, evType, evHoleNum, output evReady);

endinterface

// File: rtl/hit_event_scheduler_collector.sv
// hit_collector: per-ball sticky hit collector, frame snapshot and priority encode.
// Ports: clk, reset (sync, active high), sof (frame boundary), ball_dr (this ball),
// other_dr (the other ball), borders_dr, hole_dr, mask_bb (cooldown mask),
// enc_c (encoded event: the snapshot being taken on sof, else the held snapshot).
module hit_collector
    import hit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sof,
    input  logic                 ball_dr,
    input  logic                 other_dr,
    input  logic                 borders_dr,
    input  logic [NUM_HOLES-1:0] hole_dr,
    input  logic                 mask_bb,
    output hit_enc_t             enc_c
);

    ball_hits_t hits_c;
    ball_hits_t cand_c;
    ball_hits_t coll_q;
    ball_hits_t snap_q;

    // Overlaps at the current pixel.
    always_comb begin
        hits_c.border = ball_dr & borders_dr;
        hits_c.ball   = ball_dr & other_dr;
        hits_c.hole   = {NUM_HOLES{ball_dr}} & hole_dr;
    end

    // Boundary pixel counts in the ending frame; ball-ball masked during cooldown.
    always_comb begin
        cand_c.border = coll_q.border | hits_c.border;
        cand_c.ball   = (coll_q.ball | hits_c.ball) & ~mask_bb;
        cand_c.hole   = coll_q.hole | hits_c.hole;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coll_q <= '0;
            snap_q <= '0;
        end else if (sof) begin
            snap_q <= cand_c;
            coll_q <= '0;
        end else begin
            coll_q <= coll_q | hits_c;
        end
    end

    assign enc_c = encode_hits(sof ? cand_c : snap_q);

endmodule

// File: rtl/hit_event_scheduler.sv
// hit_event_scheduler: per-frame scheduler of ball hit events (white first, then red).
// Ports: clk, reset (sync, active high), startOfFrame, whiteBallDR, redBallDR,
// bordersDR, holeDR, ev (hit_event_scheduler_if.master), busy, overrun.
// Build option HIT_STATS_EN adds ballHitCount/borderHitCount/holeHitCount,
// saturating counts of transferred events per type.
module hit_event_scheduler
    import hit_pkg::*;
#(
    parameter int unsigned COOLDOWN_FRAMES = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   whiteBallDR,
    input  logic                   redBallDR,
    input  logic                   bordersDR,
    input  logic [NUM_HOLES-1:0]   holeDR,
    hit_event_scheduler_if.master  ev,
    output logic                   busy,
    output logic                   overrun
`ifdef HIT_STATS_EN
    ,
    output logic [STAT_W-1:0]      ballHitCount,
    output logic [STAT_W-1:0]      borderHitCount,
    output logic [STAT_W-1:0]      holeHitCount
`endif
);

    localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    sched_state_t  state_q, state_d;
    logic          ev_valid_q, ev_valid_d;
    logic          ev_ball_q, ev_ball_d;
    hit_enc_t      ev_enc_q, ev_enc_d;
    logic          white_ball_q, white_ball_d;
    logic          overrun_d;
    logic [CD_W-1:0] cd_q;
    hit_enc_t      w_enc_c, r_enc_c;
    logic          xfer_c, cd_load_c, mask_bb_c;

    assign mask_bb_c = (cd_q != '0);
    assign xfer_c    = ev_valid_q & ev.evReady;
    // A red ball-ball event only arms the cooldown if white did not already do so.
    assign cd_load_c = xfer_c & (ev_enc_q.ev == EV_BALL) & (~ev_ball_q | ~white_ball_q);

    hit_collector u_white (
        .clk        (clk),
        .reset      (reset),
        .sof        (startOfFrame),
        .ball_dr    (whiteBallDR),
        .other_dr   (redBallDR),
        .borders_dr (bordersDR),
        .hole_dr    (holeDR),
        .mask_bb    (mask_bb_c),
        .enc_c      (w_enc_c)
    );

    hit_collector u_red (
        .clk        (clk),
        .reset      (reset),
        .sof        (startOfFrame),
        .ball_dr    (redBallDR),
        .other_dr   (whiteBallDR),
        .borders_dr (bordersDR),
        .hole_dr    (holeDR),
        .mask_bb    (mask_bb_c),
        .enc_c      (r_enc_c)
    );

    // Next state and registered event outputs; a frame boundary always restarts issuing.
    always_comb begin
        state_d      = state_q;
        ev_valid_d   = ev_valid_q;
        ev_ball_d    = ev_ball_q;
        ev_enc_d     = ev_enc_q;
        white_ball_d = white_ball_q;
        overrun_d    = 1'b0;
        if (startOfFrame) begin
            overrun_d    = (state_q != IDLE);
            white_ball_d = (w_enc_c.ev == EV_BALL);
            if (w_enc_c.ev != EV_NONE) begin
                state_d    = ISSUE_W;
                ev_valid_d = 1'b1;
                ev_ball_d  = 1'b0;
                ev_enc_d   = w_enc_c;
            end else if (r_enc_c.ev != EV_NONE) begin
                state_d    = ISSUE_R;
                ev_valid_d = 1'b1;
                ev_ball_d  = 1'b1;
                ev_enc_d   = r_enc_c;
            end else begin
                state_d    = IDLE;
                ev_valid_d = 1'b0;
                ev_ball_d  = 1'b0;
                ev_enc_d   = '0;
            end
        end else begin
            case (state_q)
                ISSUE_W: begin
                    if (xfer_c) begin
                        if (r_enc_c.ev != EV_NONE) begin
                            state_d   = ISSUE_R;
                            ev_ball_d = 1'b1;
                            ev_enc_d  = r_enc_c;
                        end else begin
                            state_d    = IDLE;
                            ev_valid_d = 1'b0;
                            ev_ball_d  = 1'b0;
                            ev_enc_d   = '0;
                        end
                    end
                end
                ISSUE_R: begin
                    if (xfer_c) begin
                        state_d    = IDLE;
                        ev_valid_d = 1'b0;
                        ev_ball_d  = 1'b0;
                        ev_enc_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ev_valid_q   <= 1'b0;
            ev_ball_q    <= 1'b0;
            ev_enc_q     <= '0;
            white_ball_q <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ev_valid_q   <= ev_valid_d;
            ev_ball_q    <= ev_ball_d;
            ev_enc_q     <= ev_enc_d;
            white_ball_q <= white_ball_d;
            busy         <= (state_d != IDLE);
            overrun      <= overrun_d;
        end
    end

    // Cooldown: load beats the per-frame saturating decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            cd_q <= '0;
        end else if (cd_load_c) begin
            cd_q <= CD_W'(COOLDOWN_FRAMES);
        end else if (startOfFrame && (cd_q != '0)) begin
            cd_q <= cd_q - CD_W'(1);
        end
    end

    assign ev.evValid   = ev_valid_q;
    assign ev.evBall    = ev_ball_q;
    assign ev.evType    = ev_enc_q.ev;
    assign ev.evHoleNum = ev_enc_q.hole_num;

`ifdef HIT_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ballHitCount   <= '0;
            borderHitCount <= '0;
            holeHitCount   <= '0;
        end else if (xfer_c) begin
            if ((ev_enc_q.ev == EV_BALL) && (ballHitCount != STAT_MAX))
                ballHitCount <= ballHitCount + STAT_W'(1);
            if ((ev_enc_q.ev == EV_BORDER) && (borderHitCount != STAT_MAX))
                borderHitCount <= borderHitCount + STAT_W'(1);
            if ((ev_enc_q.ev == EV_HOLE) && (holeHitCount != STAT_MAX))
                holeHitCount <= holeHitCount + STAT_W'(1);
        end
    end
`endif

endmodule
